// File: rtl/ecb_pkg.sv
// Shared definitions for the ECB encrypt/decrypt stream blocks: FSM state
// encoding, default block/key widths and the 16-bit block-count type.
package ecb_pkg;

  localparam int unsigned DEF_BLOCK_SIZE = 64;
  localparam int unsigned DEF_KEY_SIZE   = 64;

  typedef logic [15:0] blk_cnt_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IN = 3'd1,
    DECRYPT = 3'd2,
    DRAIN   = 3'd3,
    DONE_ST = 3'd4
  } ecb_state_e;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ecb_out_fifo.sv
// In-order output buffer for plaintext blocks. Head data reads as zero
// while empty so the output port is deterministic without resetting storage.
module ecb_out_fifo
  import ecb_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_BLOCK_SIZE,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = cnt_width(DEPTH),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; push and pop together leave the count alone.
  always_comb begin
    wr_d  = push_ok ? ptr_next(wr_q) : wr_q;
    rd_d  = pop_ok  ? ptr_next(rd_q) : rd_q;
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage write for the slot at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = push_data;
  end

  // Control register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count marks which entries are meaningful.
    mem_q <= mem_d;
  end

  assign head_data = empty ? '0 : mem_q[rd_q];

endmodule

// File: rtl/gage_ingage_decipher.sv
// Iterative block decipher core. A start pulse loads the ciphertext; four
// rounds run on the following cycles and done pulses with the plaintext
// valid in that same cycle (start -> done latency of 5 cycles).
module gage_ingage_decipher
  import ecb_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int unsigned KEY_SIZE   = DEF_KEY_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_SIZE-1:0]   key,
  input  logic [BLOCK_SIZE-1:0] ciphertext,
  output logic [BLOCK_SIZE-1:0] plaintext,
  output logic                  done
);

  localparam int unsigned ROT = 13;

  logic [BLOCK_SIZE-1:0] x_q, x_d;
  logic [1:0]            rnd_q, rnd_d;
  logic                  run_q, run_d;
  logic                  done_q, done_d;

  function automatic logic [BLOCK_SIZE-1:0] rotl(input logic [BLOCK_SIZE-1:0] x,
                                                 input int unsigned n);
    return (x << n) | (x >> (BLOCK_SIZE - n));
  endfunction

  // Round key r: key rotated by 8*r bits, salted with the round number.
  function automatic logic [BLOCK_SIZE-1:0] round_key(input logic [KEY_SIZE-1:0] k,
                                                      input int unsigned r);
    return rotl(BLOCK_SIZE'(k), 8 * r) ^ BLOCK_SIZE'(r + 1);
  endfunction

  // Inverse of one encryption round: subtract the key, rotate right, unmask.
  function automatic logic [BLOCK_SIZE-1:0] dec_round(input logic [BLOCK_SIZE-1:0] x,
                                                      input logic [KEY_SIZE-1:0]   k,
                                                      input int unsigned           r);
    logic [BLOCK_SIZE-1:0] rk;
    rk = round_key(k, r);
    return rotl(x - rk, BLOCK_SIZE - ROT) ^ rk;
  endfunction

  // Round sequencing: rounds are undone from the last (3) down to the first (0).
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    x_d    = x_q;
    rnd_d  = rnd_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      x_d   = ciphertext;
      rnd_d = 2'd3;
      run_d = 1'b1;
    end else if (run_q) begin
      x_d = dec_round(x_q, key, 32'(rnd_q));
      if (rnd_q == 2'd0) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        rnd_d = rnd_q - 2'd1;
      end
    end
  end

  // Core state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update together.
    if (reset) begin
      x_q    <= '0;
      rnd_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      rnd_q  <= rnd_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign plaintext = x_q;
  assign done      = done_q;

endmodule

// File: rtl/ecb_decrypt_stream.sv
// Streaming ECB decryptor: latches key and length on start, runs one block
// at a time through the decipher core and queues plaintext in order.
// An input is only accepted once a buffer slot is free, so the core result
// always has somewhere to go.
module ecb_decrypt_stream
  import ecb_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int unsigned KEY_SIZE   = DEF_KEY_SIZE,
  parameter int unsigned OUT_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_SIZE-1:0]   key,
  input  logic [15:0]           num_blocks,
  input  logic [BLOCK_SIZE-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BLOCK_SIZE-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           blocks_out
);

  localparam int unsigned CNT_W = cnt_width(OUT_DEPTH);

  ecb_state_e            state_q, state_d;
  logic [KEY_SIZE-1:0]   key_q, key_d;
  blk_cnt_t              num_q, num_d;
  blk_cnt_t              in_cnt_q, in_cnt_d;
  blk_cnt_t              blocks_out_q, blocks_out_d;
  logic [BLOCK_SIZE-1:0] ct_q, ct_d;
  logic                  core_start_q, core_start_d;

  blk_cnt_t              in_cnt_inc;
  logic                  in_hs;
  logic                  core_done;
  logic [BLOCK_SIZE-1:0] core_pt;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [BLOCK_SIZE-1:0] fifo_head;

  assign in_cnt_inc = in_cnt_q + 16'd1;
  assign in_hs      = in_valid && in_ready;
  assign fifo_pop   = out_valid && out_ready;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_head;
  assign blocks_out = blocks_out_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_blocks != 16'd0) ? WAIT_IN : DONE_ST;
      WAIT_IN: if (in_hs) state_d = DECRYPT;
      DECRYPT: if (core_done) state_d = (in_cnt_inc == num_q) ? DRAIN : WAIT_IN;
      DRAIN:   if (fifo_empty) state_d = DONE_ST;
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; in_ready holds back while every buffer slot is spoken for.
  always_comb begin
    in_ready  = (state_q == WAIT_IN) && (fifo_count < CNT_W'(OUT_DEPTH));
    fifo_push = (state_q == DECRYPT) && core_done;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE_ST);
  end

  // Message context, captured block, core kick and delivery counter.
  always_comb begin
    key_d        = key_q;
    num_d        = num_q;
    in_cnt_d     = in_cnt_q;
    blocks_out_d = blocks_out_q;
    ct_d         = ct_q;
    core_start_d = 1'b0;
    if ((state_q == IDLE) && start) begin
      key_d        = key;
      num_d        = num_blocks;
      in_cnt_d     = '0;
      blocks_out_d = '0;
    end
    if ((state_q == WAIT_IN) && in_hs) begin
      ct_d         = in_data;
      core_start_d = 1'b1;
    end
    if (fifo_push) in_cnt_d = in_cnt_inc;
    if (fifo_pop)  blocks_out_d = blocks_out_q + 16'd1;
  end

  // Datapath register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q        <= '0;
      num_q        <= '0;
      in_cnt_q     <= '0;
      blocks_out_q <= '0;
      ct_q         <= '0;
      core_start_q <= 1'b0;
    end else begin
      key_q        <= key_d;
      num_q        <= num_d;
      in_cnt_q     <= in_cnt_d;
      blocks_out_q <= blocks_out_d;
      ct_q         <= ct_d;
      core_start_q <= core_start_d;
    end
  end

  // The slot reservation in WAIT_IN means a core result never meets a full buffer.
  always_ff @(posedge clk) begin
    if (!reset && fifo_push) assert (!fifo_full);
  end

  gage_ingage_decipher #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .KEY_SIZE   (KEY_SIZE)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .start      (core_start_q),
    .key        (key_q),
    .ciphertext (ct_q),
    .plaintext  (core_pt),
    .done       (core_done)
  );

  ecb_out_fifo #(
    .WIDTH (BLOCK_SIZE),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (core_pt),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ecb_decrypt_stream.sv
// Bench for ecb_decrypt_stream: plaintexts are encrypted by a behavioural
// encryptor model, fed in as ciphertext, and the delivered stream is
// compared against the original plaintexts in order.
module tb_ecb_decrypt_stream;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] key = '0;
  logic [15:0] num_blocks = '0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [15:0] blocks_out;

  ecb_decrypt_stream #(
    .BLOCK_SIZE (64),
    .KEY_SIZE   (64),
    .OUT_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .num_blocks (num_blocks),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .blocks_out (blocks_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Encryptor model: four rounds x = rotl(x ^ rk, 13) + rk, rk = rotl(key, 8r) ^ (r+1).
  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (n == 0) ? x : ((x << n) | (x >> (64 - n)));
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] p, input logic [63:0] k);
    logic [63:0] x, rk;
    x = p;
    for (int r = 0; r < 4; r++) begin
      rk = rotl(k, 8 * r) ^ 64'(r + 1);
      x  = rotl(x ^ rk, 13) + rk;
    end
    return x;
  endfunction

  // Scoreboard state shared between the driver and the compare process.
  logic [63:0] exp_q[$];
  logic [63:0] pt_arr[32];
  logic [63:0] ct_arr[32];
  int          acc_in = 0;
  int          pops = 0;
  int          cur_len = 0;
  int          done_cnt = 0;
  int          out_mode = 0;
  bit          prev_stall = 0;
  bit          prev_done = 0;
  logic [63:0] prev_data = '0;

  // Consumer: 0 = always ready, 1 = random, 2 = held off.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_in     = 0;
      pops       = 0;
      cur_len    = 0;
      prev_stall = 0;
      prev_done  = 0;
    end else begin
      check("blocks_out", blocks_out, pops);
      if (prev_stall) begin
        check("out_hold_valid", out_valid, 1);
        check("out_hold_data", out_data, prev_data);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", out_valid, 0);
        else if (out_ready) begin
          check("out_data", out_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      if (in_ready) begin
        check("in_ready_count", 64'(acc_in < cur_len), 1);
        check("in_ready_space", 64'((acc_in - pops) < DEPTH), 1);
      end
      if (done) begin
        check("done_single_cycle", prev_done, 0);
        check("done_blocks_out", blocks_out, cur_len);
        done_cnt++;
      end
      if (prev_done) check("busy_after_done", busy, 0);
      if (start && !busy) begin
        pops    = 0;
        acc_in  = 0;
        cur_len = int'(num_blocks);
      end
      if (in_valid && in_ready) acc_in++;
      if (out_valid && out_ready) pops++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_done  = done;
    end
  end

  // Present ct_arr[0..n-1]; optionally random gaps, key/length scrambling and a start poke.
  task automatic feed(input int n, input bit in_rand, input bit scramble, input bit poke);
    int  idx = 0;
    int  budget = 0;
    bit  hs;
    bit  poked = 0;
    while (idx < n && budget < 4000) begin
      in_valid = in_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = ct_arr[idx];
      start    = 1'b0;
      if (scramble) begin
        key        = {$urandom, $urandom};
        num_blocks = 16'($urandom);
      end
      if (poke && idx == 1 && !poked) begin
        start      = 1'b1;
        num_blocks = 16'd7;
        poked      = 1;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      budget++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("feed_all_accepted", idx, n);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input logic [63:0] k, input int n, input bit in_rand,
                         input bit scramble, input bit poke, input bit stall);
    int d0;
    for (int i = 0; i < n; i++) begin
      ct_arr[i] = enc(pt_arr[i], k);
      exp_q.push_back(pt_arr[i]);
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    key        = k;
    num_blocks = 16'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (stall) begin
      out_mode = 2;
      fork
        feed(n, in_rand, scramble, poke);
        begin
          repeat (60) @(posedge clk);
          #1;
          check("stall_buffered", acc_in, DEPTH);
          check("stall_in_ready_low", in_ready, 0);
          out_mode = 0;
        end
      join
    end else begin
      feed(n, in_rand, scramble, poke);
    end
    wait_done(d0);
    check("msg_done_count", done_cnt, d0 + 1);
    check("msg_all_delivered", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    int seen;
    int t;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_blocks_out", blocks_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Hand-computed encryptions pinning the model (key = 0).
    check("enc_pin_zero", enc(64'h0, 64'h0), 64'h0010_0180_0400_E004);
    check("enc_pin_msb", enc(64'h8000_0000_0000_0000, 64'h0), 64'h0018_0180_0400_E004);

    // Basic message, free-flowing handshakes.
    for (int i = 0; i < 4; i++) pt_arr[i] = {$urandom, $urandom};
    run_msg(64'h0123_4567_89AB_CDEF, 4, 0, 0, 0, 0);
    check("basic_blocks_out", blocks_out, 4);

    // Known plaintexts end-to-end with key 0.
    pt_arr[0] = 64'h0;
    pt_arr[1] = 64'h8000_0000_0000_0000;
    run_msg(64'h0, 2, 0, 0, 0, 0);

    // Consumer stalled: input must stop once the buffer is spoken for.
    for (int i = 0; i < 4; i++) pt_arr[i] = {$urandom, $urandom};
    run_msg(64'h0123_4567_89AB_CDEF, 4, 0, 0, 0, 1);

    // Key and length wiggled mid-message.
    for (int i = 0; i < 5; i++) pt_arr[i] = {$urandom, $urandom};
    run_msg(64'hFEDC_BA98_7654_3210, 5, 0, 1, 0, 0);
    check("latched_len_blocks_out", blocks_out, 5);

    // Empty message.
    d0 = done_cnt;
    @(posedge clk); #1;
    num_blocks = 16'd0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen  = -1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done && seen < 0) seen = c;
    end
    check("num0_done_latency", 64'(seen >= 0 && seen <= 1), 1);
    check("num0_done_count", done_cnt, d0 + 1);

    // Start pulsed while busy is ignored.
    for (int i = 0; i < 4; i++) pt_arr[i] = {$urandom, $urandom};
    run_msg(64'h0F1E_2D3C_4B5A_6978, 4, 0, 0, 1, 0);
    check("poke_blocks_out", blocks_out, 4);

    // Random gaps on both sides.
    out_mode = 1;
    for (int i = 0; i < 12; i++) pt_arr[i] = {$urandom, $urandom};
    run_msg({$urandom, $urandom}, 12, 1, 0, 0, 0);
    out_mode = 0;

    // Reset while block 2 is in the core.
    for (int i = 0; i < 4; i++) begin
      pt_arr[i] = {$urandom, $urandom};
      ct_arr[i] = enc(pt_arr[i], 64'h0123_4567_89AB_CDEF);
      exp_q.push_back(pt_arr[i]);
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    key        = 64'h0123_4567_89AB_CDEF;
    num_blocks = 16'd4;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (acc_in < 2 && t < 200) begin
      in_valid = 1'b1;
      in_data  = ct_arr[acc_in];
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    check("rst_test_two_accepted", acc_in, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_blocks_out", blocks_out, 0);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, d0);

    // Fresh one-block message after the reset.
    pt_arr[0] = {$urandom, $urandom};
    run_msg(64'h0123_4567_89AB_CDEF, 1, 0, 0, 0, 0);
    check("post_rst_blocks_out", blocks_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
